// File: rtl/dac_stream_reader.sv
// dac_stream_reader
//   Playback engine for the DAC path. Fetches packed two-channel sample words
//   from a synchronous-read RAM port starting at a latched base address, paces
//   them at a programmable sample period and drives two registered 14-bit DAC
//   channel outputs. Supports one-shot and seamless loop playback.
//
//   Optional build macro: DAC_STREAM_OFFSET_BIN_EN
//     defined   : RAM samples are two's complement; channel MSB is inverted to
//                 give offset binary, and the DAC reset value is midscale 14'h2000.
//     undefined : samples pass through unchanged, DAC reset value is 0.
//
// Ports
//   sys_clk, sys_rst   clock, asynchronous active-high reset
//   en_i               level enable (rise = start, fall = abort)
//   loop_i, base_i,    playback configuration, latched on the en_i rise
//   len_i, rate_div_i
//   mem_rd_en_o,       RAM read strobe and word address
//   mem_addr_o
//   mem_data_i         RAM read data, valid one cycle after mem_rd_en_o
//   dac_ch0_o,         registered DAC channel samples
//   dac_ch1_o
//   sample_stb_o       one-cycle pulse in the cycle the DAC outputs change
//   busy_o             high while priming or running
//   done_o             sticky one-shot completion flag
//
// state     | meaning
// ----------+-----------------------------------------------------------
// IDLE      | waiting for an en_i rising edge
// PRIME_RD  | first word read is on the RAM port
// PRIME_CAP | first word arrives; it is output immediately (first strobe)
// RUN       | paced playback; reads next word on every strobe
// DONE      | one-shot finished, outputs hold the last sample

module dac_stream_reader #(
    parameter int ADDR_WIDTH = 11,
    parameter int RATE_WIDTH = 16
) (
    input  logic                  sys_clk,
    input  logic                  sys_rst,
    input  logic                  en_i,
    input  logic                  loop_i,
    input  logic [ADDR_WIDTH-1:0] base_i,
    input  logic [ADDR_WIDTH:0]   len_i,
    input  logic [RATE_WIDTH-1:0] rate_div_i,
    output logic                  mem_rd_en_o,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    input  logic [31:0]           mem_data_i,
    output logic [13:0]           dac_ch0_o,
    output logic [13:0]           dac_ch1_o,
    output logic                  sample_stb_o,
    output logic                  busy_o,
    output logic                  done_o
);

`ifdef DAC_STREAM_OFFSET_BIN_EN
    localparam logic [13:0] DAC_RST  = 14'h2000;
    localparam logic [13:0] MSB_FLIP = 14'h2000;
`else
    localparam logic [13:0] DAC_RST  = 14'h0000;
    localparam logic [13:0] MSB_FLIP = 14'h0000;
`endif

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_PRIME_RD  = 3'd1,
        S_PRIME_CAP = 3'd2,
        S_RUN       = 3'd3,
        S_DONE      = 3'd4
    } state_t;

    state_t                state_q, state_d;
    logic                  en_d_q;
    logic [ADDR_WIDTH-1:0] base_q, base_d;
    logic [ADDR_WIDTH:0]   len_q, len_d;
    logic [RATE_WIDTH-1:0] reload_q, reload_d;
    logic                  loop_q, loop_d;
    logic [ADDR_WIDTH:0]   ridx_q, ridx_d;
    logic [RATE_WIDTH-1:0] cnt_q, cnt_d;
    logic                  fin_q, fin_d;
    logic                  dv_q, dv_d;
    logic [13:0]           pf0_q, pf0_d, pf1_q, pf1_d;
    logic                  rd_en_q, rd_en_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [13:0]           ch0_q, ch0_d, ch1_q, ch1_d;
    logic                  stb_q, stb_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;

    logic                  rise, fall, fire;
    logic [13:0]           pf0_now, pf1_now;
    logic [RATE_WIDTH-1:0] reload_in;

    // Padding bits of the packed sample word are intentionally ignored.
    logic unused_pad;
    assign unused_pad = ^{mem_data_i[31:30], mem_data_i[15:14]};

    always_comb begin
        rise = en_i & ~en_d_q;
        fall = ~en_i & en_d_q;

        // Bypass: when read data lands this cycle it is used directly, so a
        // 2-cycle sample period never sees a stale prefetch register.
        pf0_now = dv_q ? mem_data_i[13:0]  : pf0_q;
        pf1_now = dv_q ? mem_data_i[29:16] : pf1_q;

        reload_in = (rate_div_i <= RATE_WIDTH'(1)) ? RATE_WIDTH'(1) : rate_div_i;

        state_d  = state_q;
        base_d   = base_q;
        len_d    = len_q;
        reload_d = reload_q;
        loop_d   = loop_q;
        ridx_d   = ridx_q;
        cnt_d    = cnt_q;
        fin_d    = 1'b0;
        dv_d     = rd_en_q;
        pf0_d    = pf0_now;
        pf1_d    = pf1_now;
        rd_en_d  = 1'b0;
        addr_d   = addr_q;
        ch0_d    = ch0_q;
        ch1_d    = ch1_q;
        stb_d    = 1'b0;
        done_d   = done_q;
        fire     = 1'b0;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (rise) begin
                    base_d   = base_i;
                    len_d    = len_i;
                    reload_d = reload_in;
                    loop_d   = loop_i;
                    if (len_i == '0) begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = S_PRIME_RD;
                        done_d  = 1'b0;
                        rd_en_d = 1'b1;
                        addr_d  = base_i;
                        ridx_d  = (ADDR_WIDTH+1)'(1);
                    end
                end else if (fall) begin
                    state_d = S_IDLE;
                end
            end
            S_PRIME_RD: begin
                state_d = fall ? S_IDLE : S_PRIME_CAP;
            end
            S_PRIME_CAP: begin
                fire    = 1'b1;
                state_d = fall ? S_IDLE : S_RUN;
            end
            S_RUN: begin
                if (fin_q) begin
                    if (fall) begin
                        state_d = S_IDLE;
                    end else begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                    end
                end else begin
                    if (cnt_q == '0) begin
                        fire = 1'b1;
                    end else begin
                        cnt_d = cnt_q - RATE_WIDTH'(1);
                    end
                    if (fall) begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (fire) begin
            ch0_d = pf0_now ^ MSB_FLIP;
            ch1_d = pf1_now ^ MSB_FLIP;
            stb_d = 1'b1;
            cnt_d = reload_q;
            // ridx is the index of the next word to read; reaching len means
            // the word just output is the last of the window.
            if (ridx_q == len_q) begin
                if (loop_q) begin
                    rd_en_d = 1'b1;
                    addr_d  = base_q;
                    ridx_d  = (ADDR_WIDTH+1)'(1);
                end else begin
                    fin_d = 1'b1;
                end
            end else begin
                rd_en_d = 1'b1;
                addr_d  = base_q + ridx_q[ADDR_WIDTH-1:0];
                ridx_d  = ridx_q + (ADDR_WIDTH+1)'(1);
            end
        end

        // An abort suppresses any read or completion decided this cycle.
        if (fall && state_q != S_IDLE && state_q != S_DONE) begin
            rd_en_d = 1'b0;
            fin_d   = 1'b0;
        end

        busy_d = (state_d == S_PRIME_RD) || (state_d == S_PRIME_CAP) || (state_d == S_RUN);
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state_q  <= S_IDLE;
            // Reset the delayed enable high so an enable held across reset is
            // not mistaken for a new start; a fall seen in IDLE is harmless.
            en_d_q   <= 1'b1;
            base_q   <= '0;
            len_q    <= '0;
            reload_q <= '0;
            loop_q   <= 1'b0;
            ridx_q   <= '0;
            cnt_q    <= '0;
            fin_q    <= 1'b0;
            dv_q     <= 1'b0;
            pf0_q    <= '0;
            pf1_q    <= '0;
            rd_en_q  <= 1'b0;
            addr_q   <= '0;
            ch0_q    <= DAC_RST;
            ch1_q    <= DAC_RST;
            stb_q    <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            en_d_q   <= en_i;
            base_q   <= base_d;
            len_q    <= len_d;
            reload_q <= reload_d;
            loop_q   <= loop_d;
            ridx_q   <= ridx_d;
            cnt_q    <= cnt_d;
            fin_q    <= fin_d;
            dv_q     <= dv_d;
            pf0_q    <= pf0_d;
            pf1_q    <= pf1_d;
            rd_en_q  <= rd_en_d;
            addr_q   <= addr_d;
            ch0_q    <= ch0_d;
            ch1_q    <= ch1_d;
            stb_q    <= stb_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign mem_rd_en_o  = rd_en_q;
    assign mem_addr_o   = addr_q;
    assign dac_ch0_o    = ch0_q;
    assign dac_ch1_o    = ch1_q;
    assign sample_stb_o = stb_q;
    assign busy_o       = busy_q;
    assign done_o       = done_q;

endmodule

// File: doc/dac_stream_reader.md
Name: dac_stream_reader

Overview:
- Playback engine for the DAC path; the read-side counterpart of the ADC capture writer that fills DMEM port 2.
- Reads packed two-channel sample words from a synchronous-read RAM port, starting at a CSR-programmed base address.
- Paces the samples at a programmable rate and drives two 14-bit DAC channel registers, in one-shot or loop mode.
- Sits between DMEM port 2 and the dac block; control comes from CSR fields (en, len, base, rate, loop) and status returns through done/busy.

Parameters:
- ADDR_WIDTH, 11, word-address width of the sample RAM port; len and base share this range.
- RATE_WIDTH, 16, width of the rate divider input.

Ports:
- sys_clk  in  1  system clock; the only clock.
- sys_rst  in  1  asynchronous active-high reset.
- en_i  in  1  level enable; rising edge starts playback, falling edge aborts it.
- loop_i  in  1  1 = restart from base after the last sample; 0 = one-shot.
- base_i  in  ADDR_WIDTH  first word address.
- len_i  in  ADDR_WIDTH+1  number of words, 0..2^ADDR_WIDTH.
- rate_div_i  in  RATE_WIDTH  sample period in cycles = rate_div_i+1; values 0 and 1 are treated as 1.
- mem_rd_en_o  out  1  RAM read strobe.
- mem_addr_o  out  ADDR_WIDTH  RAM word address.
- mem_data_i  in  32  RAM read data, valid exactly 1 cycle after mem_rd_en_o; ch0 in [13:0], ch1 in [29:16], bits [15:14] and [31:30] ignored.
- dac_ch0_o  out  14  DAC channel 0 sample (registered).
- dac_ch1_o  out  14  DAC channel 1 sample (registered).
- sample_stb_o  out  1  one-cycle pulse in the cycle the dac outputs change.
- busy_o  out  1  high in PRIME and RUN.
- done_o  out  1  sticky; set when a one-shot run completes.

Behaviour:
- Reset values: all outputs 0; state IDLE. Reset mid-run aborts immediately, with no further RAM reads.
- en_i edge detection uses an internal 1-cycle delayed copy of en_i. len, base, rate and loop are latched on the rising edge; later changes have no effect until the next start.
- IDLE: wait for the en_i rising edge.
  - len_i==0 → DONE next cycle, done_o=1, no reads.
  - Otherwise clear done_o, then go to PRIME.
- PRIME:
  - Cycle 0: mem_rd_en_o=1, mem_addr_o=base.
  - Cycle 1: capture mem_data_i into the prefetch register, set idx=1, go to RUN, and load the rate counter so that the first strobe fires in the next cycle.
- RUN:
  - A down-counter reloads with the effective divider on every strobe.
  - On a strobe: dac_ch0_o/dac_ch1_o take the prefetch register and sample_stb_o=1. If more words remain (or loop_i is latched), issue a read of base+idx in the same cycle; the prefetch register reloads the following cycle.
  - The effective period is ≥2 cycles, so the prefetch is always valid before the next strobe and no underrun is possible.
- Address arithmetic: mem_addr_o = (base + idx) mod 2^ADDR_WIDTH, so the window wraps at the top of the RAM. idx increments per read.
  - When idx reaches len: in loop mode idx→0 and base is read next, giving a seamless wrap with no extra cycles. In one-shot mode no further reads are issued.
- One-shot end:
  - The strobe that outputs the final (len-th) word is the last one.
  - In the next cycle: state DONE, done_o=1, busy_o=0.
  - The outputs hold the last sample indefinitely.
- DONE: stay until the en_i rising edge, which behaves as a new start from IDLE. An en_i fall in DONE moves to IDLE and leaves done_o unchanged.
- Abort: an en_i falling edge in PRIME or RUN goes to IDLE next cycle.
  - Outputs hold their current value; done_o stays 0.
  - Any in-flight read data is discarded.
- Simultaneous events: an en_i fall in the same cycle as the final one-shot strobe is treated as an abort; the strobe still updates the outputs, but done_o stays 0.
- len = 2^ADDR_WIDTH plays the full RAM once.

Optional Feature:
- Macro: DAC_STREAM_OFFSET_BIN_EN.
- When defined:
  - Samples in RAM are two's complement; the MSB (bit 13) of each channel is inverted on its way to dac_ch*_o, giving offset binary for the DAC.
  - The reset and abort-to-IDLE-from-reset value of both outputs is 14'h2000 (midscale).
- When undefined: samples pass through unchanged and the reset value is 0.

Test Plan:
- Reset, then en_i rise with base=0x010, len=4, rate_div=3, loop=0, RAM words 0x0001_0002… → reads at 0x010..0x013; sample_stb_o every 4 cycles; ch0=2,4,6,8 and ch1=1,3,5,7; done_o=1 one cycle after the 4th strobe; outputs then hold 8/7.
- base=0x7FE, len=4, loop=1, rate_div=0 → addresses 0x7FE,0x7FF,0x000,0x001,0x7FE…; strobe every 2 cycles with no gap at the wrap; done_o never set.
- len=0 and en_i rise → no mem_rd_en_o; done_o=1 on the next cycle; busy_o stays 0.
- en_i fall after the 2nd strobe of len=8 → IDLE next cycle; outputs hold sample 2; done_o=0; no further reads. A new rise restarts from base.
- sys_rst pulse mid-RUN → all outputs 0 asynchronously (0x2000 with DAC_STREAM_OFFSET_BIN_EN), and no reads after release until the next en_i rise.
- With DAC_STREAM_OFFSET_BIN_EN, RAM ch0=0x3FFF (-1) → dac_ch0_o=0x1FFF; ch0=0x0000 → 0x2000.
